// File: rtl/sort_result_streamer.sv
// -----------------------------------------------------------------------------
// sort_result_streamer
//
// Drains the bubble-sort processor's data memory after a sort has finished.
// On start it reads the element count n from SIZE_ADDR, then walks addresses
// 0..n-1 and streams each word out over a valid/ready interface. While the
// words pass, it checks that the array is in non-decreasing unsigned order.
// The memory read port is combinational: mem_rdata follows mem_addr within
// the same cycle, so mem_addr is registered one edge ahead of its use.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   begin a drain (only honoured in IDLE)
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when the drain completes
//   mem_addr   out  read address to the data memory
//   mem_rd     out  read strobe, high in READ_N and FETCH
//   mem_rdata  in   combinational read data
//   out_valid  out  out_data/out_index/out_last are valid
//   out_ready  in   consumer accepts the current word
//   out_data   out  element value
//   out_index  out  element address
//   out_last   out  marks element n-1
//   sorted_ok  out  no descending pair seen so far in this drain
//   n_clamped  out  the stored n was larger than the addressable range
// -----------------------------------------------------------------------------
module sort_result_streamer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int SIZE_ADDR = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              sorted_ok,
  output logic              n_clamped
);

  typedef enum logic [2:0] {
    IDLE,
    READ_N,
    FETCH,
    SEND,
    FINISH
  } state_t;

  // Largest count that fits in an address-wide register.
  localparam logic [ADDR_W-1:0] N_MAX = '1;

  state_t              state;
  logic [ADDR_W-1:0]   n_reg;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   prev;

  // Saturated element count taken from the size word.
  logic                n_over;
  logic [ADDR_W-1:0]   n_sat;

  assign n_over = (mem_rdata > DATA_W'(N_MAX));
  assign n_sat  = n_over ? N_MAX : mem_rdata[ADDR_W-1:0];

  // NOTE: all state and outputs live in one clocked block and use
  // non-blocking assignments, so every register sees the pre-edge values of
  // the others regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset branch covers only control and output registers;
    // n_reg, idx and prev are always written before they are read, so they
    // are left out of reset.
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      sorted_ok <= 1'b1;
      n_clamped <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ_N;
            busy      <= 1'b1;
            mem_rd    <= 1'b1;
            mem_addr  <= ADDR_W'(SIZE_ADDR);
            sorted_ok <= 1'b1;
            n_clamped <= 1'b0;
          end
        end

        READ_N: begin
          n_reg     <= n_sat;
          n_clamped <= n_over;
          if (n_sat == '0) begin
            state  <= FINISH;
            mem_rd <= 1'b0;
            done   <= 1'b1;
          end else begin
            // Present address 0 now so its data is ready during FETCH.
            idx      <= '0;
            mem_addr <= '0;
            state    <= FETCH;
          end
        end

        FETCH: begin
          out_data  <= mem_rdata;
          out_index <= idx;
          out_last  <= (idx == n_reg - ADDR_W'(1));
          if ((idx != '0) && (mem_rdata < prev)) begin
            sorted_ok <= 1'b0;
          end
          prev      <= mem_rdata;
          out_valid <= 1'b1;
          mem_rd    <= 1'b0;
          state     <= SEND;
        end

        SEND: begin
          // Outputs hold until the consumer takes the word.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              idx      <= idx + ADDR_W'(1);
              mem_addr <= idx + ADDR_W'(1);
              mem_rd   <= 1'b1;
              state    <= FETCH;
            end
          end
        end

        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_sort_result_streamer
//
// Self-checking bench for sort_result_streamer. A 256x32 memory with a
// combinational read port feeds the DUT. Before each drain the reference
// model walks the memory image and queues the words the DUT should emit,
// together with the running sorted flag; a monitor on the falling edge pops
// and compares on every handshake and checks that stalled outputs hold.
// -----------------------------------------------------------------------------
module tb_sort_result_streamer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] index;
    logic              last;
    logic              ok;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              sorted_ok;
  logic              n_clamped;

  logic [DATA_W-1:0] mem [256];
  exp_t              exp_q[$];
  bit                exp_sorted;
  bit                exp_clamped;
  bit                rand_ready;
  int                checks;
  int                errors;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  sort_result_streamer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SIZE_ADDR(255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .sorted_ok(sorted_ok),
    .n_clamped(n_clamped)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what a drain of the current memory image must produce.
  task automatic push_expected();
    int   n;
    bit   ok;
    exp_t e;
    exp_clamped = (mem[255] > 32'd255);
    n  = exp_clamped ? 255 : int'(mem[255]);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && mem[i] < mem[i-1]) ok = 1'b0;
      e.data  = mem[i];
      e.index = ADDR_W'(i);
      e.last  = (i == n - 1);
      e.ok    = ok;
      exp_q.push_back(e);
    end
    exp_sorted = ok;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {out_valid, busy, done, mem_rd, out_last, n_clamped, sorted_ok}, 7'b0000001);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_index"}, out_index, 0);
  endtask

  // Runs one drain starting mid-cycle. exp_lat < 0 skips the latency check;
  // stall_idx >= 0 holds out_ready low for 5 cycles on that element.
  task automatic run_drain(input int exp_lat, input int stall_idx, input bit busy_starts);
    int edges;
    int stalls;
    bit seen;
    push_expected();
    if (stall_idx >= 0) out_ready = 1'b1;
    start  = 1'b1;
    edges  = 0;
    stalls = 0;
    seen   = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      edges++;
      start = busy_starts ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stall_idx >= 0) begin
        if (out_valid && out_index == ADDR_W'(stall_idx) && stalls < 5) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (exp_lat >= 0) check("done_latency", edges, exp_lat);
    check("words_left", exp_q.size(), 0);
    check("final_sorted_ok", sorted_ok, exp_sorted);
    check("final_n_clamped", n_clamped, exp_clamped);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("idle_after_done", {busy, done}, 2'b00);
    check("flags_held", {sorted_ok, n_clamped}, {exp_sorted, exp_clamped});
  endtask

  // Monitor: compare every accepted word, and hold-stability while stalled.
  initial begin
    bit                stalled;
    logic [DATA_W-1:0] h_data;
    logic [ADDR_W-1:0] h_index;
    logic              h_last;
    exp_t              e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        stalled = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (stalled) begin
          check("stall_hold", {out_data, out_index, out_last}, {h_data, h_index, h_last});
        end
        if (out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_word: got data 0x%0h index %0d, expected none", out_data, out_index);
          end else begin
            e = exp_q.pop_front();
            check("word_data", out_data, e.data);
            check("word_index", out_index, e.index);
            check("word_last", out_last, e.last);
            check("running_sorted_ok", sorted_ok, e.ok);
            check("busy_in_send", busy, 1);
          end
        end else begin
          stalled = 1'b1;
          h_data  = out_data;
          h_index = out_index;
          h_last  = out_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] sorted_vals [16];
    logic [DATA_W-1:0] acc;
    int                n;
    bit                found;

    sorted_vals = '{5, 5, 9, 14, 14, 17, 63, 69, 71, 75, 100, 234, 298, 2354, 4784, 7755};
    checks     = 0;
    errors     = 0;
    rand_ready = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sorted array, no stall: 2*16+2 edges until done.
    mem[255] = 16;
    for (int i = 0; i < 16; i++) mem[i] = sorted_vals[i];
    run_drain(34, -1, 1'b0);

    // Unsorted array: flag drops on index 3 and stays low.
    mem[255] = 4;
    mem[0] = 5; mem[1] = 71; mem[2] = 2354; mem[3] = 63;
    run_drain(10, -1, 1'b0);

    // Backpressure: five stall cycles on word 1 of 3.
    mem[255] = 3;
    mem[0] = 40; mem[1] = 41; mem[2] = 39;
    run_drain(13, 1, 1'b0);

    // n = 0: done after the second edge, no words.
    mem[255] = 0;
    run_drain(2, -1, 1'b0);

    // n = 1: single word flagged last.
    mem[255] = 1;
    mem[0] = 32'hDEAD_BEEF;
    run_drain(4, -1, 1'b0);

    // Oversized n: clamped to 255 words, indices 0..254.
    mem[255] = 1000;
    for (int i = 0; i < 255; i++) mem[i] = 32'(i * 3);
    run_drain(512, -1, 1'b0);

    // start during the done cycle is ignored; the next cycle it is accepted.
    mem[255] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("n0_done_pulse", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    check("start_in_done_ignored", {busy, done}, 2'b00);
    @(posedge clk); #1;
    check("start_after_done_taken", busy, 1);
    start = 1'b0;
    @(posedge clk); #1;
    check("second_n0_done", done, 1);
    @(posedge clk); #1;

    // Reset in SEND of word 2 of 8, then replay from index 0.
    mem[255] = 8;
    for (int i = 0; i < 8; i++) mem[i] = 32'(100 + i);
    push_expected();
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid && out_index == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_word2", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("no_done_after_reset", {done, busy, out_valid}, 3'b000);
    run_drain(18, -1, 1'b0);

    // Randomized drains: random sizes, data, backpressure and stray starts.
    rand_ready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 40);
      mem[255] = n;
      acc = $urandom_range(0, 1000);
      for (int i = 0; i < 256 - 1; i++) begin
        if (t % 3 == 0) mem[i] = $urandom;
        else begin
          acc    = acc + $urandom_range(0, 50);
          mem[i] = acc;
        end
      end
      if (t % 5 == 4 && n > 1) mem[n-1] = 0;
      run_drain(-1, -1, 1'b1);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
